// File: rtl/state_msg_scroller.sv
// Status-message driver: maps the 4-bit system state to a row of seven-segment character
// codes, shown statically or scrolled right-to-left. Optional blink via STATE_MSG_BLINK_EN.
module state_msg_scroller #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned STEP_DIV   = 25_000_000,
    parameter int unsigned GAP        = 4,
    parameter logic [4:0]  BLANK_CODE = 5'h1F
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              state,
    input  logic                    scroll,
    output logic [5*NUM_DIGITS-1:0] bcd,
    output logic                    frame_start
);

    localparam logic [3:0] STATE_NORMAL     = 4'h0;
    localparam logic [3:0] STATE_BORDERLINE = 4'h1;
    localparam logic [3:0] STATE_ATTENTION  = 4'h2;
    localparam logic [3:0] STATE_EMERGENCY  = 4'h3;

    localparam logic [4:0] BCD_1 = 5'h01;
    localparam logic [4:0] BCD_A = 5'h0A;
    localparam logic [4:0] BCD_B = 5'h0B;
    localparam logic [4:0] BCD_D = 5'h0D;
    localparam logic [4:0] BCD_F = 5'h0F;
    localparam logic [4:0] BCD_G = 5'h10;
    localparam logic [4:0] BCD_L = 5'h11;
    localparam logic [4:0] BCD_N = 5'h12;
    localparam logic [4:0] BCD_O = 5'h13;
    localparam logic [4:0] BCD_R = 5'h14;
    localparam logic [4:0] BCD_T = 5'h15;

    localparam int unsigned RING_LEN = 4 + GAP;
    localparam int unsigned POS_W    = $clog2(RING_LEN);
    localparam int unsigned PRE_W    = $clog2(STEP_DIV);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(RING_LEN - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

    logic [3:0]              last_state_q, last_state_d;
    logic [PRE_W-1:0]        prescaler_q, prescaler_d;
    logic [POS_W-1:0]        pos_q, pos_d;
    logic [5*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic                    frame_start_q, frame_start_d;
`ifdef STATE_MSG_BLINK_EN
    logic                    phase_q, phase_d;
`endif

    logic        step;
    logic        state_change;
    logic        blank_all;
    logic [4:0]  msg [4];
    int unsigned ring_idx;
    logic [4:0]  ring_char;

    always_comb begin
        step         = (prescaler_q == PRE_LAST);
        state_change = (state != last_state_q);
        last_state_d = state;

        // A state change restarts the message and wins over a coincident step.
        if (state_change) begin
            prescaler_d   = '0;
            pos_d         = '0;
            frame_start_d = 1'b0;
        end else begin
            prescaler_d = step ? '0 : prescaler_q + PRE_W'(1);
            if (!scroll) begin
                pos_d         = '0;
                frame_start_d = 1'b0;
            end else if (step) begin
                frame_start_d = (pos_q == POS_LAST);
                pos_d         = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
            end else begin
                pos_d         = pos_q;
                frame_start_d = 1'b0;
            end
        end

`ifdef STATE_MSG_BLINK_EN
        phase_d   = state_change ? 1'b0 : (step ? ~phase_q : phase_q);
        blank_all = (last_state_d == STATE_EMERGENCY) && phase_d;
`else
        blank_all = 1'b0;
`endif

        unique case (last_state_d)
            STATE_NORMAL:     begin msg[0] = BCD_G; msg[1] = BCD_O; msg[2] = BCD_O; msg[3] = BCD_D; end
            STATE_BORDERLINE: begin msg[0] = BCD_B; msg[1] = BCD_O; msg[2] = BCD_R; msg[3] = BCD_D; end
            STATE_ATTENTION:  begin msg[0] = BCD_A; msg[1] = BCD_T; msg[2] = BCD_T; msg[3] = BCD_N; end
            STATE_EMERGENCY:  begin msg[0] = BCD_F; msg[1] = BCD_A; msg[2] = BCD_1; msg[3] = BCD_L; end
            default:          begin msg[0] = BCD_F; msg[1] = BCD_F; msg[2] = BCD_F; msg[3] = BCD_F; end
        endcase

        // Outputs are computed from next-state values so bcd and frame_start stay aligned.
        bcd_d     = '0;
        ring_idx  = 0;
        ring_char = BLANK_CODE;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            ring_idx  = (32'(pos_d) + 32'(k)) % RING_LEN;
            ring_char = (ring_idx < 4) ? msg[ring_idx[1:0]] : BLANK_CODE;
            if (blank_all) begin
                ring_char = BLANK_CODE;
            end
            bcd_d[5*(NUM_DIGITS-1-k) +: 5] = ring_char;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_state_q  <= 4'hF;
            prescaler_q   <= '0;
            pos_q         <= '0;
            bcd_q         <= {NUM_DIGITS{BLANK_CODE}};
            frame_start_q <= 1'b0;
`ifdef STATE_MSG_BLINK_EN
            phase_q       <= 1'b0;
`endif
        end else begin
            last_state_q  <= last_state_d;
            prescaler_q   <= prescaler_d;
            pos_q         <= pos_d;
            bcd_q         <= bcd_d;
            frame_start_q <= frame_start_d;
`ifdef STATE_MSG_BLINK_EN
            phase_q       <= phase_d;
`endif
        end
    end

    assign bcd         = bcd_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_state_msg_scroller.sv
// Directed bench for state_msg_scroller: a 4-digit and a 6-digit instance, STEP_DIV = 4, GAP = 4.
module tb_state_msg_scroller;

    localparam logic [3:0] ST_NORMAL = 4'h0;
    localparam logic [3:0] ST_ATTN   = 4'h2;
    localparam logic [3:0] ST_EMERG  = 4'h3;
    localparam logic [3:0] ST_BAD    = 4'h9;

    localparam logic [4:0] K_ = 5'h1F;
    localparam logic [4:0] K1 = 5'h01;
    localparam logic [4:0] KA = 5'h0A;
    localparam logic [4:0] KD = 5'h0D;
    localparam logic [4:0] KF = 5'h0F;
    localparam logic [4:0] KG = 5'h10;
    localparam logic [4:0] KL = 5'h11;
    localparam logic [4:0] KN = 5'h12;
    localparam logic [4:0] KO = 5'h13;
    localparam logic [4:0] KT = 5'h15;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  state;
    logic        scroll;
    logic [19:0] bcd4;
    logic [29:0] bcd6;
    logic        fs4;
    logic        fs6;

    int checks   = 0;
    int failures = 0;

    logic [19:0] attn_frames [8];
    logic [19:0] good_f, fail_f, blank4;
    logic [19:0] blink_exp;
    int          pulses;

    state_msg_scroller #(
        .NUM_DIGITS(4), .STEP_DIV(4), .GAP(4), .BLANK_CODE(5'h1F)
    ) u_dut4 (
        .clk(clk), .rst(rst), .state(state), .scroll(scroll),
        .bcd(bcd4), .frame_start(fs4)
    );

    state_msg_scroller #(
        .NUM_DIGITS(6), .STEP_DIV(4), .GAP(4), .BLANK_CODE(5'h1F)
    ) u_dut6 (
        .clk(clk), .rst(rst), .state(state), .scroll(scroll),
        .bcd(bcd6), .frame_start(fs6)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [29:0] got, input logic [29:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        attn_frames[0] = {KA, KT, KT, KN};
        attn_frames[1] = {KT, KT, KN, K_};
        attn_frames[2] = {KT, KN, K_, K_};
        attn_frames[3] = {KN, K_, K_, K_};
        attn_frames[4] = {K_, K_, K_, K_};
        attn_frames[5] = {K_, K_, K_, KA};
        attn_frames[6] = {K_, K_, KA, KT};
        attn_frames[7] = {K_, KA, KT, KT};
        good_f = {KG, KO, KO, KD};
        fail_f = {KF, KA, K1, KL};
        blank4 = {K_, K_, K_, K_};

        // Reset with static NORMAL
        rst = 1'b1; state = ST_NORMAL; scroll = 1'b0;
        tick(3);
        chk("reset_bcd4", 30'(bcd4), 30'(blank4));
        chk("reset_bcd6", bcd6, {K_, K_, K_, K_, K_, K_});
        chk("reset_fs", 30'(fs4), 30'd0);
        rst = 1'b0;
        tick(1);
        chk("static_good", 30'(bcd4), 30'(good_f));
        chk("static_good6", bcd6, {KG, KO, KO, KD, K_, K_});
        tick(20);
        chk("static_good_held", 30'(bcd4), 30'(good_f));
        chk("static_no_fs", 30'(fs4), 30'd0);

        // Scroll ATTN
        state = ST_ATTN; scroll = 1'b1;
        tick(1);
        chk("attn_p0", 30'(bcd4), 30'(attn_frames[0]));
        chk("attn_change_no_fs", 30'(fs4), 30'd0);
        tick(3);
        chk("attn_p0_hold", 30'(bcd4), 30'(attn_frames[0]));
        tick(1);
        chk("attn_p1", 30'(bcd4), 30'(attn_frames[1]));
        for (int p = 2; p < 8; p++) begin
            tick(4);
            chk($sformatf("attn_p%0d", p), 30'(bcd4), 30'(attn_frames[p]));
            chk($sformatf("attn_fs_p%0d", p), 30'(fs4), 30'd0);
        end
        tick(4);
        chk("attn_wrap_p0", 30'(bcd4), 30'(attn_frames[0]));
        chk("attn_wrap_fs", 30'(fs4), 30'd1);
        tick(1);
        chk("attn_fs_one_cycle", 30'(fs4), 30'd0);
        tick(3);
        chk("attn_after_wrap_p1", 30'(bcd4), 30'(attn_frames[1]));
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            tick(1);
            if (fs4) pulses++;
        end
        chk("attn_fs_per_32", 30'(pulses), 30'd1);

        // Change to EMERGENCY at pos 5, prescaler 2
        state = ST_NORMAL;
        tick(1);
        chk("normal_scroll_p0", 30'(bcd4), 30'(good_f));
        tick(22);
        chk("normal_p5", 30'(bcd4), 30'({K_, K_, K_, KG}));
        state = ST_EMERG;
        tick(1);
        chk("emerg_restart", 30'(bcd4), 30'(fail_f));
        chk("emerg_restart_no_fs", 30'(fs4), 30'd0);
        tick(3);
        chk("emerg_no_early_step", 30'(bcd4), 30'(fail_f));
        tick(1);
        chk("emerg_step_4", 30'(bcd4), 30'({KA, K1, KL, K_}));

        // Invalid state, static
        scroll = 1'b0; state = ST_BAD;
        tick(1);
        chk("bad_bcd4", 30'(bcd4), 30'({KF, KF, KF, KF}));
        chk("bad_bcd6", bcd6, {KF, KF, KF, KF, K_, K_});
        tick(10);
        chk("bad_bcd6_held", bcd6, {KF, KF, KF, KF, K_, K_});

        // Blink (or not) on EMERGENCY in static mode
`ifdef STATE_MSG_BLINK_EN
        blink_exp = blank4;
`else
        blink_exp = fail_f;
`endif
        state = ST_EMERG;
        tick(1);
        chk("blink_on_c0", 30'(bcd4), 30'(fail_f));
        tick(3);
        chk("blink_on_c3", 30'(bcd4), 30'(fail_f));
        tick(1);
        chk("blink_c4", 30'(bcd4), 30'(blink_exp));
        tick(4);
        chk("blink_c8", 30'(bcd4), 30'(fail_f));
        tick(4);
        chk("blink_c12", 30'(bcd4), 30'(blink_exp));
        state = ST_NORMAL;
        tick(1);
        chk("blink_end_normal", 30'(bcd4), 30'(good_f));

        // Reset mid-scroll at pos 3
        state = ST_ATTN; scroll = 1'b1;
        tick(1);
        tick(12);
        chk("rst_pre_p3", 30'(bcd4), 30'(attn_frames[3]));
        tick(1);
        rst = 1'b1;
        tick(1);
        chk("rst_mid_blank", 30'(bcd4), 30'(blank4));
        chk("rst_mid_fs", 30'(fs4), 30'd0);
        rst = 1'b0;
        tick(1);
        chk("rst_restart_p0", 30'(bcd4), 30'(attn_frames[0]));
        tick(4);
        chk("rst_restart_p1", 30'(bcd4), 30'(attn_frames[1]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
